// File: rtl/branch_condition_unit.sv
// Branch resolution unit: snapshots NZCV (with write bypass), evaluates the branch
// condition, and hands a registered redirect to the PC logic over valid/ready.
module branch_condition_unit #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [1:0]        br_kind,
  input  logic [3:0]        br_cond,
  input  logic [ADDR_W-1:0] br_reg,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_offset,
  input  logic [3:0]        flags_nzcv,
  input  logic              flags_update,
  input  logic [3:0]        flags_next,
  output logic              redirect_valid,
  input  logic              redirect_ready,
  output logic [ADDR_W-1:0] redirect_target,
  output logic              redirect_taken,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  taken_count
);

  typedef enum logic [1:0] {IDLE, EVAL, REDIRECT} state_t;

  localparam logic [1:0] KIND_BCOND = 2'b00;
  localparam logic [1:0] KIND_CBZ   = 2'b01;
  localparam logic [1:0] KIND_CBNZ  = 2'b10;

  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, res;
    {n, z, c, v} = nzcv;
    case (cond)
      4'd0:    res = z;
      4'd1:    res = !z;
      4'd2:    res = c;
      4'd3:    res = !c;
      4'd4:    res = n;
      4'd5:    res = !n;
      4'd6:    res = v;
      4'd7:    res = !v;
      4'd8:    res = c && !z;
      4'd9:    res = !c || z;
      4'd10:   res = (n == v);
      4'd11:   res = (n != v);
      4'd12:   res = !z && (n == v);
      4'd13:   res = z || (n != v);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  state_t            state_q, state_d;
  logic              br_ready_q, br_ready_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [ADDR_W-1:0] redirect_target_q, redirect_target_d;
  logic              redirect_taken_q, redirect_taken_d;
  logic [CNT_W-1:0]  branch_count_q, branch_count_d;
  logic [CNT_W-1:0]  taken_count_q, taken_count_d;

  logic [1:0]        kind_q, kind_d;
  logic [3:0]        cond_q, cond_d;
  logic [ADDR_W-1:0] reg_q, reg_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic [3:0]        flags_q, flags_d;

  logic              accept;
  logic              taken;

  assign accept = br_valid && br_ready_q;

  always_comb begin
    case (kind_q)
      KIND_BCOND: taken = cond_holds(cond_q, flags_q);
      KIND_CBZ:   taken = (reg_q == '0);
      KIND_CBNZ:  taken = (reg_q != '0);
      default:    taken = 1'b1;
    endcase
  end

  always_comb begin
    state_d           = state_q;
    br_ready_d        = br_ready_q;
    redirect_valid_d  = redirect_valid_q;
    redirect_target_d = redirect_target_q;
    redirect_taken_d  = redirect_taken_q;
    branch_count_d    = branch_count_q;
    taken_count_d     = taken_count_q;
    kind_d            = kind_q;
    cond_d            = cond_q;
    reg_d             = reg_q;
    pc_d              = pc_q;
    offset_d          = offset_q;
    flags_d           = flags_q;
    case (state_q)
      IDLE: begin
        br_ready_d       = 1'b1;
        redirect_valid_d = 1'b0;
        if (accept) begin
          kind_d     = br_kind;
          cond_d     = br_cond;
          reg_d      = br_reg;
          pc_d       = br_pc;
          offset_d   = br_offset;
          // A same-edge flag write is bypassed so the branch never waits on the register.
          flags_d    = flags_update ? flags_next : flags_nzcv;
          br_ready_d = 1'b0;
          state_d    = EVAL;
        end
      end
      EVAL: begin
        redirect_taken_d  = taken;
        redirect_target_d = taken ? (pc_q + (offset_q << 2)) : (pc_q + ADDR_W'(4));
        branch_count_d    = branch_count_q + CNT_W'(1);
        taken_count_d     = taken_count_q + CNT_W'(taken);
        redirect_valid_d  = 1'b1;
        state_d           = REDIRECT;
      end
      REDIRECT: begin
        if (redirect_ready) begin
          redirect_valid_d = 1'b0;
          br_ready_d       = 1'b1;
          state_d          = IDLE;
        end
      end
      default: begin
        redirect_valid_d = 1'b0;
        br_ready_d       = 1'b0;
        state_d          = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= IDLE;
      br_ready_q        <= 1'b0;
      redirect_valid_q  <= 1'b0;
      redirect_target_q <= '0;
      redirect_taken_q  <= 1'b0;
      branch_count_q    <= '0;
      taken_count_q     <= '0;
    end else begin
      state_q           <= state_d;
      br_ready_q        <= br_ready_d;
      redirect_valid_q  <= redirect_valid_d;
      redirect_target_q <= redirect_target_d;
      redirect_taken_q  <= redirect_taken_d;
      branch_count_q    <= branch_count_d;
      taken_count_q     <= taken_count_d;
    end
  end

  // Request payload is only consumed in EVAL after a fresh accept, so it needs no reset.
  always_ff @(posedge clk) begin
    kind_q   <= kind_d;
    cond_q   <= cond_d;
    reg_q    <= reg_d;
    pc_q     <= pc_d;
    offset_q <= offset_d;
    flags_q  <= flags_d;
  end

  assign br_ready        = br_ready_q;
  assign redirect_valid  = redirect_valid_q;
  assign redirect_target = redirect_target_q;
  assign redirect_taken  = redirect_taken_q;
  assign branch_count    = branch_count_q;
  assign taken_count     = taken_count_q;

endmodule

// File: tb/tb_branch_condition_unit.sv
// Scoreboard bench for branch_condition_unit: expected redirects are queued on drive
// and compared when the redirect handshake completes.
module tb_branch_condition_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_ready;
  logic [1:0]  br_kind = '0;
  logic [3:0]  br_cond = '0;
  logic [63:0] br_reg = '0;
  logic [63:0] br_pc = '0;
  logic [63:0] br_offset = '0;
  logic [3:0]  flags_nzcv = '0;
  logic        flags_update = 1'b0;
  logic [3:0]  flags_next = '0;
  logic        redirect_valid;
  logic        redirect_ready = 1'b1;
  logic [63:0] redirect_target;
  logic        redirect_taken;
  logic [31:0] branch_count;
  logic [31:0] taken_count;

  typedef struct packed {
    logic [63:0] target;
    logic        taken;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  exp_t        last_e;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_bc = '0;
  logic [31:0] exp_tc = '0;

  branch_condition_unit #(.ADDR_W(64), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .br_valid(br_valid), .br_ready(br_ready),
    .br_kind(br_kind), .br_cond(br_cond), .br_reg(br_reg),
    .br_pc(br_pc), .br_offset(br_offset),
    .flags_nzcv(flags_nzcv), .flags_update(flags_update), .flags_next(flags_next),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_target(redirect_target), .redirect_taken(redirect_taken),
    .branch_count(branch_count), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: ARM-style pairing, odd codes invert the even condition (except 14/15).
  function automatic logic model_taken(input logic [1:0] k, input logic [3:0] c,
                                       input logic [63:0] r, input logic [3:0] nz);
    logic n, z, cf, v, base;
    {n, z, cf, v} = nz;
    if (k == 2'b11) return 1'b1;
    if (k == 2'b01) return (r == 64'd0);
    if (k == 2'b10) return (r != 64'd0);
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return (c[3:1] != 3'd7 && c[0]) ? ~base : base;
  endfunction

  task automatic drive_and_push(input logic [1:0] k, input logic [3:0] c, input logic [63:0] r,
                                input logic [63:0] pc, input logic [63:0] off,
                                input logic [3:0] nz, input logic fu, input logic [3:0] fn);
    exp_t e;
    br_valid     = 1'b1;
    br_kind      = k;
    br_cond      = c;
    br_reg       = r;
    br_pc        = pc;
    br_offset    = off;
    flags_nzcv   = nz;
    flags_update = fu;
    flags_next   = fn;
    e.taken  = model_taken(k, c, r, fu ? fn : nz);
    e.target = e.taken ? pc + (off << 2) : pc + 64'd4;
    sb_q.push_back(e);
    last_e = e;
    exp_bc = exp_bc + 32'd1;
    if (e.taken) exp_tc = exp_tc + 32'd1;
  endtask

  // Returns at posedge+1 with the request accepted (unit in EVAL).
  task automatic send(input logic [1:0] k, input logic [3:0] c, input logic [63:0] r,
                      input logic [63:0] pc, input logic [63:0] off,
                      input logic [3:0] nz, input logic fu, input logic [3:0] fn);
    int t = 0;
    @(negedge clk);
    while (!br_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!br_ready) check("accept_timeout", 64'(br_ready), 64'd1);
    drive_and_push(k, c, r, pc, off, nz, fu, fn);
    @(posedge clk);
    #1;
    br_valid     = 1'b0;
    flags_update = 1'b0;
    flags_next   = $urandom_range(0, 15);
    flags_nzcv   = $urandom_range(0, 15);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    @(negedge clk);
    while ((sb_q.size() != 0 || !br_ready) && t < 30) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_drain"}, 64'(sb_q.size()), 64'd0);
    check({tag, "_bc"}, 64'(branch_count), 64'(exp_bc));
    check({tag, "_tc"}, 64'(taken_count), 64'(exp_tc));
  endtask

  task automatic wait_redirect_valid(input string tag);
    int t = 0;
    @(negedge clk);
    while (!redirect_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_rv_timeout"}, 64'(redirect_valid), 64'd1);
  endtask

  task automatic apply_reset_now(input string tag);
    reset = 1'b0;
    #1;
    check({tag, "_rv"}, 64'(redirect_valid), 64'd0);
    check({tag, "_rdy"}, 64'(br_ready), 64'd0);
    check({tag, "_tgt"}, redirect_target, 64'd0);
    check({tag, "_tkn"}, 64'(redirect_taken), 64'd0);
    check({tag, "_bc"}, 64'(branch_count), 64'd0);
    check({tag, "_tc"}, 64'(taken_count), 64'd0);
    sb_q.delete();
    exp_bc = '0;
    exp_tc = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset && redirect_valid && redirect_ready) begin
      if (sb_q.size() == 0) begin
        check("spurious_redirect", 64'(sb_q.size()), 64'd1);
      end else begin
        mon_e = sb_q.pop_front();
        check("target", redirect_target, mon_e.target);
        check("taken", 64'(redirect_taken), 64'(mon_e.taken));
      end
    end
  end

  initial begin
    logic [31:0] bc_hold;
    exp_t        e_hold;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", 64'(br_ready), 64'd0);
    check("rst_rv", 64'(redirect_valid), 64'd0);
    check("rst_tgt", redirect_target, 64'd0);
    check("rst_tkn", 64'(redirect_taken), 64'd0);
    check("rst_bc", 64'(branch_count), 64'd0);
    check("rst_tc", 64'(taken_count), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", 64'(br_ready), 64'd1);

    // BEQ with Z set: taken to 0x110, with latency checks.
    send(2'b00, 4'd0, 64'd0, 64'h100, 64'd4, 4'b0100, 1'b0, 4'd0);
    @(negedge clk);
    check("eval_rv", 64'(redirect_valid), 64'd0);
    check("eval_rdy", 64'(br_ready), 64'd0);
    @(negedge clk);
    check("lat_rv", 64'(redirect_valid), 64'd1);
    check("beq_tgt", redirect_target, 64'h110);
    check("beq_tkn", 64'(redirect_taken), 64'd1);
    check("beq_bc", 64'(branch_count), 64'd1);
    check("beq_tc", 64'(taken_count), 64'd1);
    drain("beq");

    // Bypass: flags_next wins over flags_nzcv on the accept edge.
    send(2'b00, 4'd1, 64'd0, 64'h2000, 64'd8, 4'b0000, 1'b1, 4'b0100);
    drain("bypass");

    // Sweep every condition code against every flag value, bypass randomly used.
    for (int c = 0; c < 16; c++) begin
      for (int nz = 0; nz < 16; nz++) begin
        logic fu;
        fu = 1'($urandom_range(0, 1));
        send(2'b00, 4'(c), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             fu ? 4'($urandom_range(0, 15)) : 4'(nz), fu, 4'(nz));
      end
    end
    drain("sweep");

    // Compare-and-branch and unconditional, including address wrap.
    send(2'b01, 4'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd1, 4'd0, 1'b0, 4'd0);
    drain("cbz_wrap");
    send(2'b10, 4'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd5, 4'd0, 1'b0, 4'd0);
    drain("cbnz_wrap");
    send(2'b01, 4'd0, 64'd7, 64'h4000, 64'hFFFF_FFFF_FFFF_FFFE, 4'd0, 1'b0, 4'd0);
    send(2'b10, 4'd0, 64'd7, 64'h4000, 64'hFFFF_FFFF_FFFF_FFFE, 4'd0, 1'b0, 4'd0);
    send(2'b11, 4'd0, 64'd0, 64'h8000, 64'h10, 4'd0, 1'b0, 4'd0);
    drain("cb_misc");

    // Back-pressure: redirect held for 5 cycles while a second request waits.
    redirect_ready = 1'b0;
    send(2'b00, 4'd12, 64'd0, 64'h300, 64'd3, 4'b1001, 1'b0, 4'd0);
    e_hold  = last_e;
    bc_hold = exp_bc;
    drive_and_push(2'b00, 4'd13, 64'd0, 64'h500, 64'd2, 4'b1000, 1'b0, 4'd0);
    wait_redirect_valid("hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rv", 64'(redirect_valid), 64'd1);
      check("hold_rdy", 64'(br_ready), 64'd0);
      check("hold_tgt", redirect_target, e_hold.target);
      check("hold_tkn", 64'(redirect_taken), 64'(e_hold.taken));
      check("hold_bc", 64'(branch_count), 64'(bc_hold));
    end
    @(posedge clk);
    #1;
    redirect_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle_after_release", 64'(br_ready), 64'd1);
    @(posedge clk);
    #1;
    br_valid = 1'b0;
    drain("hold");

    // Reset during EVAL.
    send(2'b11, 4'd0, 64'd0, 64'h600, 64'd1, 4'd0, 1'b0, 4'd0);
    #2;
    apply_reset_now("rst_eval");
    send(2'b00, 4'd0, 64'd0, 64'h100, 64'd4, 4'b0100, 1'b0, 4'd0);
    drain("after_rst_eval");

    // Reset during REDIRECT.
    redirect_ready = 1'b0;
    send(2'b11, 4'd0, 64'd0, 64'h700, 64'd9, 4'd0, 1'b0, 4'd0);
    wait_redirect_valid("rst_redir");
    #2;
    apply_reset_now("rst_redir");
    redirect_ready = 1'b1;
    send(2'b00, 4'd10, 64'd0, 64'h900, 64'd6, 4'b0000, 1'b0, 4'd0);
    drain("after_rst_redir");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
